// File: rtl/program_loader.sv
// Boot-time instruction loader: streams words into instruction memory, holds the
// core in reset until the whole image is written, and reports a running checksum.
module program_loader #(
    parameter int INSTRUCTION_LEN      = 16,
    parameter int INSTRUCTION_MEM_SIZE = 8,
    localparam int AW = $clog2(INSTRUCTION_MEM_SIZE)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [INSTRUCTION_LEN-1:0] in_data,
    output logic                       in_ready,
    output logic                       imem_we,
    output logic [AW-1:0]              imem_addr,
    output logic [INSTRUCTION_LEN-1:0] imem_wdata,
    output logic                       core_reset,
    output logic                       done,
    output logic [INSTRUCTION_LEN-1:0] checksum
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(INSTRUCTION_MEM_SIZE - 1);

    state_t                     state_q, state_d;
    logic [AW-1:0]              count_q, count_d;
    logic [INSTRUCTION_LEN-1:0] checksum_q, checksum_d;
    logic                       imem_we_q, imem_we_d;
    logic [AW-1:0]              imem_addr_q, imem_addr_d;
    logic [INSTRUCTION_LEN-1:0] imem_wdata_q, imem_wdata_d;
    logic                       core_reset_q, core_reset_d;
    logic                       done_q, done_d;
    logic                       handshake;

    // A start pulse during LOAD restarts the image, so the word offered in that cycle is refused.
    assign in_ready  = (state_q == LOAD) && !start;
    assign handshake = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        checksum_d   = checksum_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_reset_d = 1'b0;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD;
                    count_d    = '0;
                    checksum_d = '0;
                end
            end
            LOAD: begin
                if (start) begin
                    count_d    = '0;
                    checksum_d = '0;
                end else if (handshake) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = count_q;
                    imem_wdata_d = in_data;
                    checksum_d   = checksum_q + in_data;
                    if (count_q == LAST_ADDR) begin
                        state_d = DRAIN;
                        count_d = '0;
                    end else begin
                        count_d = count_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                state_d = RUN;
            end
            RUN: begin
                // Release is driven from RUN itself, so the core leaves reset two edges after the last word.
                if (start) begin
                    state_d    = LOAD;
                    count_d    = '0;
                    checksum_d = '0;
                end else begin
                    core_reset_d = 1'b1;
                    done_d       = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            checksum_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_reset_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            checksum_q   <= checksum_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_reset_q <= core_reset_d;
            done_q       <= done_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_reset = core_reset_q;
    assign done       = done_q;
    assign checksum   = checksum_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios with literal expectations
// plus a long random run, all compared every cycle against a behavioural model.
module tb_program_loader;

    localparam int W    = 16;
    localparam int SIZE = 8;
    localparam int AW   = $clog2(SIZE);

    logic          clk;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [W-1:0]  imem_wdata;
    logic          core_reset;
    logic          done;
    logic [W-1:0]  checksum;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] words [SIZE];

    program_loader #(
        .INSTRUCTION_LEN(W),
        .INSTRUCTION_MEM_SIZE(SIZE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .done(done),
        .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: words accepted in the current load, running sum, and edges elapsed since the
    // final word (-1 while no image is complete). The core is released two edges after it.
    bit      m_loading;
    int      m_accepted;
    int      m_sum;
    int      m_after;
    int      m_entry;
    bit      m_we;
    int      m_addr;
    int      m_wdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_loading  = 1'b0;
            m_accepted = 0;
            m_sum      = 0;
            m_after    = -1;
            m_we       = 1'b0;
            m_addr     = 0;
            m_wdata    = 0;
        end else begin
            m_entry = m_after;
            m_we    = 1'b0;
            if (m_entry >= 0 && m_entry < 1000) m_after = m_entry + 1;
            if (start) begin
                if (m_entry != 0) begin
                    m_loading  = 1'b1;
                    m_accepted = 0;
                    m_sum      = 0;
                    m_after    = -1;
                end
            end else if (m_loading && in_valid) begin
                m_we       = 1'b1;
                m_addr     = m_accepted;
                m_wdata    = int'(in_data);
                m_sum      = (m_sum + int'(in_data)) % 65536;
                m_accepted = m_accepted + 1;
                if (m_accepted == SIZE) begin
                    m_loading = 1'b0;
                    m_after   = 0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            checkOutput("in_ready", 32'(in_ready), 32'(m_loading && !start));
            checkOutput("imem_we", 32'(imem_we), 32'(m_we));
            if (m_we) begin
                checkOutput("imem_addr", 32'(imem_addr), 32'(m_addr));
                checkOutput("imem_wdata", 32'(imem_wdata), 32'(m_wdata));
            end
            checkOutput("core_reset", 32'(core_reset), 32'(m_after >= 2));
            checkOutput("done", 32'(done), 32'(m_after >= 2));
            checkOutput("checksum", 32'(checksum), 32'(m_sum));
        end
    end

    task automatic applyStimulus(input logic s, input logic v, input logic [W-1:0] d);
        start    = s;
        in_valid = v;
        in_data  = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // gapMode 0: back-to-back, 1: two idle cycles between words, 2: random gaps.
    task automatic sendImage(input int gapMode, input logic [W-1:0] expSum);
        applyStimulus(1'b1, 1'b0, W'($urandom));
        for (int i = 0; i < SIZE; i++) begin
            if (i > 0 && gapMode == 1) begin
                applyStimulus(1'b0, 1'b0, W'($urandom));
                applyStimulus(1'b0, 1'b0, W'($urandom));
            end
            if (gapMode == 2) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++)
                    applyStimulus(1'b0, 1'b0, W'($urandom));
            end
            applyStimulus(1'b0, 1'b1, words[i]);
            if (i == 0) begin
                checkOutput("first_we", 32'(imem_we), 32'd1);
                checkOutput("first_addr", 32'(imem_addr), 32'd0);
                checkOutput("first_wdata", 32'(imem_wdata), 32'(words[0]));
            end
        end
        checkOutput("drain_we", 32'(imem_we), 32'd1);
        checkOutput("drain_addr", 32'(imem_addr), 32'(SIZE - 1));
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("edge1_core_reset", 32'(core_reset), 32'd0);
        checkOutput("edge1_we", 32'(imem_we), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("release_core_reset", 32'(core_reset), 32'd1);
        checkOutput("release_done", 32'(done), 32'd1);
        checkOutput("final_checksum", 32'(checksum), 32'(expSum));
    endtask

    initial begin
        logic [W-1:0] sum;
        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        $display("[TB] reset values");
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_we", 32'(imem_we), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_wdata", 32'(imem_wdata), 32'd0);
        checkOutput("rst_core_reset", 32'(core_reset), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_checksum", 32'(checksum), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, W'($urandom));
            checkOutput("idle_no_write", 32'(imem_we), 32'd0);
        end

        $display("[TB] streaming load");
        for (int i = 0; i < SIZE; i++) words[i] = W'(16'h1001 + i);
        sendImage(0, 16'h8024);

        $display("[TB] gapped load");
        sum = '0;
        for (int i = 0; i < SIZE; i++) begin
            words[i] = W'($urandom);
            sum      = sum + words[i];
        end
        sendImage(1, sum);

        $display("[TB] checksum wrap");
        for (int i = 0; i < SIZE; i++) words[i] = 16'hFFFF;
        sendImage(0, 16'hFFF8);

        $display("[TB] restart mid-load");
        applyStimulus(1'b1, 1'b0, 16'h0);
        checkOutput("run_start_core_reset", 32'(core_reset), 32'd0);
        checkOutput("run_start_done", 32'(done), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'hA0A0);
        applyStimulus(1'b1, 1'b1, 16'h5555);
        checkOutput("restart_no_write", 32'(imem_we), 32'd0);
        checkOutput("restart_checksum", 32'(checksum), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'h0001);
        checkOutput("restart_we", 32'(imem_we), 32'd1);
        checkOutput("restart_addr", 32'(imem_addr), 32'd0);
        checkOutput("restart_wdata", 32'(imem_wdata), 32'h0001);
        for (int i = 2; i <= SIZE; i++) applyStimulus(1'b0, 1'b1, W'(i));
        applyStimulus(1'b0, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b0, 16'h0);
        checkOutput("restart_done", 32'(done), 32'd1);
        checkOutput("restart_sum", 32'(checksum), 32'h0024);

        $display("[TB] reset mid-load");
        applyStimulus(1'b1, 1'b0, 16'h0);
        applyStimulus(1'b0, 1'b1, 16'h1111);
        applyStimulus(1'b0, 1'b1, 16'h2222);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_core_reset", 32'(core_reset), 32'd0);
        checkOutput("async_we", 32'(imem_we), 32'd0);
        checkOutput("async_done", 32'(done), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, W'($urandom));
            checkOutput("post_reset_idle_we", 32'(imem_we), 32'd0);
        end

        $display("[TB] random gapped load");
        sum = '0;
        for (int i = 0; i < SIZE; i++) begin
            words[i] = W'($urandom);
            sum      = sum + words[i];
        end
        sendImage(2, sum);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++)
            applyStimulus(($urandom % 16) == 0, ($urandom % 2) == 1, W'($urandom));
        repeat (3) applyStimulus(1'b0, 1'b0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time instruction loader for the multi-cycle 16-bit processor. It accepts instruction words over a valid/ready stream and writes them sequentially into the processor's instruction memory. It holds the core in reset until the whole memory is written, then releases it. It also reports a running checksum of the loaded image to the host/bench.

## Interface

Parameters:
- INSTRUCTION_LEN, 16, width of one instruction word
- INSTRUCTION_MEM_SIZE, 8, number of instruction memory entries (≥2); AW = $clog2(INSTRUCTION_MEM_SIZE)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle request to (re)load the image
- in_valid  in  1  in_data holds a word
- in_data  in  INSTRUCTION_LEN  instruction word
- in_ready  out  1  loader accepts the word this cycle
- imem_we  out  1  instruction memory write enable
- imem_addr  out  AW  write address
- imem_wdata  out  INSTRUCTION_LEN  write data
- core_reset  out  1  active-low reset to the processor; 0 while not RUN
- done  out  1  image fully written, core running
- checksum  out  INSTRUCTION_LEN  sum of accepted words mod 2^INSTRUCTION_LEN

## Operation

- States: IDLE, LOAD, DRAIN, RUN. All outputs are registered except in_ready.
- Reset (reset=0, asynchronous):
  - state=IDLE, count=0, checksum=0, imem_we=0, imem_addr=0, imem_wdata=0, core_reset=0, done=0.
  - in_ready=0.
- IDLE:
  - in_ready=0, core_reset=0.
  - start → LOAD; count and checksum are cleared.
- LOAD:
  - in_ready = ~start.
  - Handshake is in_valid & in_ready at a rising edge. On a handshake:
    - next cycle imem_we=1, imem_addr=count, imem_wdata=in_data
    - checksum += in_data (wraps)
    - count++
  - No handshake → imem_we=0 next cycle.
  - Handshake with count = INSTRUCTION_MEM_SIZE-1 → DRAIN.
- DRAIN:
  - Lasts exactly 1 cycle. imem_we=1 for the last word; in_ready=0.
  - start is ignored.
  - Always → RUN.
- RUN:
  - core_reset=1, done=1, imem_we=0, in_ready=0. checksum holds.
  - start → LOAD: core_reset=0 and done=0 from the next cycle; count and checksum cleared.
- start in LOAD:
  - Restarts the load: count=0, checksum=0.
  - Any word presented that cycle is not accepted (in_ready=0).
  - The next accepted word goes to address 0.
- in_data while in_ready=0 is ignored. in_valid may drop at any time; only handshakes advance count.
- Address never exceeds INSTRUCTION_MEM_SIZE-1. No wrap: DRAIN is entered at the last address.

## Timing

- Write latency: the imem write occurs 1 cycle after the handshake (imem_we high during cycle k+1 for a handshake at edge k).
- Last handshake at edge k:
  - imem_we high cycle k+1 (DRAIN)
  - core_reset=1 and done=1 from edge k+2
- Sustained throughput is 1 word/cycle. A full load takes INSTRUCTION_MEM_SIZE+1 cycles from the first handshake to core_reset rising.
- checksum updates at the handshake edge and is visible the following cycle.
- Asynchronous reset mid-operation immediately forces core_reset=0, imem_we=0, done=0. Partially written memory is not cleared.
- Deassertion of reset is synchronised externally; the block leaves IDLE only on start.

## Test plan

- Reset values: hold reset=0 for 5 cycles, then release → all outputs 0, in_ready=0; no write occurs without start.
- Full load, streaming:
  - Stimulus: start, then 8 back-to-back words 0x1001..0x1008.
  - Writes: addr 0..7 with matching data, each 1 cycle after its handshake.
  - Release: core_reset and done rise 2 cycles after the last handshake.
  - Result: checksum=0x8024.
- Gapped valid:
  - Stimulus: in_valid toggled 1,0,0,1,…
  - Required: imem_we asserts only after handshakes; addresses stay contiguous 0..7; final checksum matches the words sent.
- Checksum wrap: 8 words of 0xFFFF → checksum=0xFFF8, done=1.
- Restart mid-load:
  - Stimulus: after 3 words (0xA0A0 each), pulse start while in_valid=1 with 0x5555.
  - Required: 0x5555 is not accepted; checksum=0; the next word 0x0001 is written to addr 0.
  - Then: completing 8 words gives done=1.
- Reload from RUN and reset mid-load:
  - Start in RUN: core_reset drops to 0 the next cycle.
  - Then: assert reset=0 asynchronously after 2 words → core_reset=0, imem_we=0 and done=0 immediately, before the next clock edge; state returns to IDLE.
